// File: rtl/mem_arbiter_pkg.sv
// Shared FSM/grant encodings and default widths for mem_arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic       {GNT_I, GNT_D}         gnt_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

endpackage

// File: rtl/mem_arbiter_fetch_buf.sv
// One-entry fetch buffer (valid/tag/data), used by mem_arbiter when
// MEM_ARBITER_FETCH_BUF_EN is defined.
module fetch_buf
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inv,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data
);

  logic              valid_q;
  logic [ADDR_W-1:0] tag_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill) begin
      valid_q <= 1'b1;
      tag_q   <= fill_addr;
      data_q  <= fill_data;
    end else if (inv && (inv_addr == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_addr);
  assign hit_data = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fair two-requester (fetch/data) arbiter onto one req/ack memory port.
// Optional one-entry fetch buffer enabled by MEM_ARBITER_FETCH_BUF_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o
);

  state_t            state_q;
  gnt_t              last_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              grant_d;
  gnt_t              pick_d;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  logic              hit_ack;
  logic              ack_i_mem;
  logic              ack_d_mem;

  assign ack_i_mem = (state_q == BUSY_I) && mem_ack_i;
  assign ack_d_mem = (state_q == BUSY_D) && mem_ack_i;
  assign hit_ack   = (state_q == IDLE) && if_req_i && !d_req_i && buf_hit;

  // A pending data request always beats a buffer hit, even on a tie.
  always_comb begin
    grant_d = 1'b0;
    pick_d  = GNT_I;
    if (state_q == IDLE) begin
      if (d_req_i && if_req_i) begin
        grant_d = 1'b1;
        pick_d  = (buf_hit || (last_q == GNT_I)) ? GNT_D : GNT_I;
      end else if (d_req_i) begin
        grant_d = 1'b1;
        pick_d  = GNT_D;
      end else if (if_req_i && !buf_hit) begin
        grant_d = 1'b1;
        pick_d  = GNT_I;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_q      <= GNT_I;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            mem_req_q <= 1'b1;
            last_q    <= pick_d;
            if (pick_d == GNT_D) begin
              state_q     <= BUSY_D;
              mem_we_q    <= d_we_i;
              mem_addr_q  <= d_addr_i;
              mem_wdata_q <= d_wdata_i;
            end else begin
              state_q     <= BUSY_I;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr_i;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARBITER_FETCH_BUF_EN
  fetch_buf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fetch_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .fill       (ack_i_mem),
    .fill_addr  (mem_addr_q),
    .fill_data  (mem_rdata_i),
    .inv        (grant_d && (pick_d == GNT_D) && d_we_i),
    .inv_addr   (d_addr_i),
    .lookup_addr(if_addr_i),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  assign if_ack_o    = ack_i_mem || hit_ack;
  assign if_data_o   = ack_i_mem ? mem_rdata_i : (hit_ack ? buf_data : '0);
  assign d_ack_o     = ack_d_mem;
  assign d_rdata_o   = ack_d_mem ? mem_rdata_i : '0;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_o     = (if_req_i && !if_ack_o) || (d_req_i && !d_ack_o);

endmodule
